// File: rtl/eth_pkg.sv
// Shared Ethernet constants and the rx framer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;
  localparam int          ETH_MIN_LEN     = 64;
  localparam int          ETH_MAX_LEN     = 1518;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PREAM = 2'd1,
    ST_BODY  = 2'd2,
    ST_DROP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/eth_crc32_d8.sv
// Next-state of the reflected Ethernet CRC-32 after one byte, LSB first.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Eight unrolled shift/xor steps, data bit 0 enters first.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = (crc_out[0] ^ data[i]) ? ((crc_out >> 1) ^ ETH_CRC_POLY) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/eth_rx_framer.sv
// GMII rx framer: strips preamble/SFD and FCS, delimits the body with sop/eop and a verdict.
// Latency: body byte N leaves 1 cycle after byte N+5 is sampled; last byte 1 cycle after rx_dv falls.
// Backpressure: none; the consumer must accept every o_data_vl beat.
module eth_rx_framer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_data,
  input  logic             i_data_vl,
  output logic [7:0]       o_data,
  output logic             o_data_vl,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_crc_ok,
  output logic [15:0]      o_len,
  output logic [CNT_W-1:0] o_frames_ok,
  output logic [CNT_W-1:0] o_frames_bad
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  rx_state_t       state;
  logic [15:0]     cnt;       // bytes seen after the SFD, saturating
  logic [31:0]     crc;
  logic [31:0]     crc_nxt;
  logic [4:0][7:0] dly;       // dly[4] is the oldest byte, i.e. the next one out
  logic            vl_q;
  logic [15:0]     cnt_inc;
  logic            frame_ok;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (i_data),
    .crc_out (crc_nxt)
  );

  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign frame_ok = (crc == ETH_CRC_RESIDUE) && (cnt >= MIN_L) && (cnt <= MAX_L);

  // Previous rx_dv, deliberately tracked through reset so a frame already in flight
  // when reset releases is recognised and dropped rather than mistaken for a new start.
  always_ff @(posedge clk) begin
    vl_q <= i_data_vl;
  end

  // Framing FSM with registered outputs; the 5-byte delay line hides the FCS.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      crc          <= ETH_CRC_INIT;
      dly          <= '0;
      o_data       <= '0;
      o_data_vl    <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_crc_ok     <= 1'b0;
      o_len        <= '0;
      o_frames_ok  <= '0;
      o_frames_bad <= '0;
    end else begin
      o_data    <= '0;
      o_data_vl <= 1'b0;
      o_sop     <= 1'b0;
      o_eop     <= 1'b0;
      o_crc_ok  <= 1'b0;
      o_len     <= '0;
      case (state)
        ST_IDLE: begin
          if (i_data_vl) begin
            state <= (i_data == ETH_PREAMBLE && !vl_q) ? ST_PREAM : ST_DROP;
          end
        end
        ST_PREAM: begin
          if (!i_data_vl) begin
            state <= ST_IDLE;
          end else if (i_data == ETH_SFD) begin
            state <= ST_BODY;
            crc   <= ETH_CRC_INIT;
            cnt   <= '0;
          end else if (i_data != ETH_PREAMBLE) begin
            state <= ST_DROP;
          end
        end
        ST_BODY: begin
          if (i_data_vl) begin
            dly <= {dly[3:0], i_data};
            crc <= crc_nxt;
            cnt <= cnt_inc;
            // Line already full: the oldest byte cannot be FCS, release it.
            if (cnt >= 16'd5) begin
              o_data    <= dly[4];
              o_data_vl <= 1'b1;
              o_sop     <= (cnt == 16'd5);
            end
          end else begin
            state <= ST_IDLE;
            dly   <= '0;
            if (cnt >= 16'd5) begin
              // dly[3:0] hold the FCS; dly[4] is the last body byte.
              o_data    <= dly[4];
              o_data_vl <= 1'b1;
              o_sop     <= (cnt == 16'd5);
              o_eop     <= 1'b1;
              o_crc_ok  <= frame_ok;
              o_len     <= cnt - 16'd4;
              if (frame_ok) begin
                if (!(&o_frames_ok)) o_frames_ok <= o_frames_ok + CNT_W'(1);
              end else begin
                if (!(&o_frames_bad)) o_frames_bad <= o_frames_bad + CNT_W'(1);
              end
            end else begin
              // Nothing beyond a (partial) FCS arrived: discard silently but count it.
              if (!(&o_frames_bad)) o_frames_bad <= o_frames_bad + CNT_W'(1);
            end
          end
        end
        ST_DROP: begin
          if (!i_data_vl) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_framer.sv
// Scoreboarded bench for eth_rx_framer: directed frames plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_eth_rx_framer;
  import eth_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_data_vl;
  logic [7:0]  o_data;
  logic        o_data_vl;
  logic        o_sop;
  logic        o_eop;
  logic        o_crc_ok;
  logic [15:0] o_len;
  logic [15:0] o_frames_ok;
  logic [15:0] o_frames_bad;

  always #4 clk = ~clk;

  eth_rx_framer #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_data       (i_data),
    .i_data_vl    (i_data_vl),
    .o_data       (o_data),
    .o_data_vl    (o_data_vl),
    .o_sop        (o_sop),
    .o_eop        (o_eop),
    .o_crc_ok     (o_crc_ok),
    .o_len        (o_len),
    .o_frames_ok  (o_frames_ok),
    .o_frames_bad (o_frames_bad)
  );

  typedef struct packed {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic        ok;
    logic [15:0] len;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] post_q[$];   // every byte sent after the SFD
  int n_cmp   = 0;
  int n_bad   = 0;
  int exp_ok  = 0;
  int exp_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every valid beat must match the head of the expectation queue.
  always @(negedge clk) begin : mon
    beat_t got;
    beat_t e;
    got = {o_data, o_sop, o_eop, o_crc_ok, o_len};
    if (o_data_vl) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat: got data=%0h sop=%0b eop=%0b ok=%0b len=%0d, expected none",
                 o_data, o_sop, o_eop, o_crc_ok, o_len);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL beat: got data=%0h sop=%0b eop=%0b ok=%0b len=%0d expected data=%0h sop=%0b eop=%0b ok=%0b len=%0d",
                   o_data, o_sop, o_eop, o_crc_ok, o_len, e.d, e.sop, e.eop, e.ok, e.len);
        end
      end
    end else if (o_sop || o_eop || o_crc_ok || (o_len != 16'd0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray_flags: got sop=%0b eop=%0b ok=%0b len=%0d expected all 0 while idle",
               o_sop, o_eop, o_crc_ok, o_len);
    end
  end

  // Standard Ethernet CRC-32 over the first n bytes of post_q (before final inversion).
  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ post_q[i][b]) c = (c >> 1) ^ ETH_CRC_POLY;
        else                     c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic build(input int len, input bit corrupt, input bit ramp);
    logic [31:0] fcs;
    post_q.delete();
    for (int i = 0; i < len; i++) post_q.push_back(ramp ? 8'(i) : 8'($urandom));
    fcs = ~crc_of(len);
    if (corrupt) fcs[0] = ~fcs[0];
    for (int k = 0; k < 4; k++) post_q.push_back(fcs[8*k +: 8]);
  endtask

  // Reference: last 4 bytes are the FCS; frame good iff FCS equals the body's CRC and length legal.
  task automatic model();
    int          n = post_q.size();
    logic [31:0] rx;
    logic [31:0] want;
    bit          ok;
    if (n <= 4) begin
      exp_bad++;
      return;
    end
    want = ~crc_of(n - 4);
    rx   = {post_q[n-1], post_q[n-2], post_q[n-3], post_q[n-4]};
    ok   = (rx == want) && (n >= 64) && (n <= 1518);
    for (int i = 0; i < n - 4; i++) begin
      exp_q.push_back('{d: post_q[i], sop: (i == 0), eop: (i == n - 5),
                        ok: (i == n - 5) && ok, len: (i == n - 5) ? 16'(n - 4) : 16'd0});
    end
    if (ok) exp_ok++;
    else    exp_bad++;
  endtask

  task automatic put(input logic vl, input logic [7:0] d);
    @(negedge clk);
    i_data_vl = vl;
    i_data    = d;
  endtask

  task automatic send(input int npre, input int gap);
    model();
    repeat (npre) put(1'b1, ETH_PREAMBLE);
    put(1'b1, ETH_SFD);
    foreach (post_q[i]) put(1'b1, post_q[i]);
    repeat (gap) put(1'b0, 8'h00);
  endtask

  task automatic send_nosfd(input int npre, input int nextra);
    repeat (npre) put(1'b1, ETH_PREAMBLE);
    put(1'b1, 8'($urandom_range(0, 8'h54)));
    repeat (nextra) put(1'b1, 8'($urandom));
    put(1'b0, 8'h00);
  endtask

  task automatic check_counters(input string tag);
    @(negedge clk);
    check({tag, "_frames_ok"},  32'(o_frames_ok),  32'(exp_ok));
    check({tag, "_frames_bad"}, 32'(o_frames_bad), 32'(exp_bad));
  endtask

  initial begin
    rst       = 1'b1;
    i_data    = 8'h00;
    i_data_vl = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data_vl", 32'(o_data_vl), 32'd0);
    check("reset_data",    32'(o_data), 32'd0);
    check("reset_eop",     32'(o_eop), 32'd0);
    check("reset_ok_cnt",  32'(o_frames_ok), 32'd0);
    check("reset_bad_cnt", 32'(o_frames_bad), 32'd0);
    rst = 1'b0;
    put(1'b0, 8'h00);

    // Good 60-byte ramp frame, then the same with FCS bit 0 flipped.
    build(60, 1'b0, 1'b1); send(7, 2); check_counters("good60");
    build(60, 1'b1, 1'b1); send(7, 2); check_counters("badfcs");
    // Runt with a correct FCS.
    build(40, 1'b0, 1'b1); send(7, 2); check_counters("runt40");
    // Preamble followed by a non-SFD byte: ignored entirely.
    repeat (8) put(1'b1, ETH_PREAMBLE);
    put(1'b1, 8'h00);
    repeat (30) put(1'b1, 8'($urandom));
    put(1'b0, 8'h00);
    check_counters("nosfd");
    build(60, 1'b0, 1'b0); send(7, 2); check_counters("after_nosfd");

    // Reset pulsed while body byte 20 of a 100-byte frame is on the wire.
    build(100, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++)
      exp_q.push_back('{d: post_q[i], sop: (i == 0), eop: 1'b0, ok: 1'b0, len: 16'd0});
    repeat (7) put(1'b1, ETH_PREAMBLE);
    put(1'b1, ETH_SFD);
    for (int i = 0; i < 20; i++) put(1'b1, post_q[i]);
    @(negedge clk);
    rst = 1'b1; i_data_vl = 1'b1; i_data = post_q[20];
    @(negedge clk);
    rst = 1'b0; i_data = post_q[21];
    exp_ok = 0; exp_bad = 0;
    check("rst_mid_data_vl", 32'(o_data_vl), 32'd0);
    check("rst_mid_eop",     32'(o_eop), 32'd0);
    check("rst_mid_pending", 32'(exp_q.size()), 32'd0);
    check("rst_mid_ok_cnt",  32'(o_frames_ok), 32'd0);
    for (int i = 22; i < 104; i++) put(1'b1, post_q[i]);
    put(1'b0, 8'h00);
    check_counters("after_abort");
    build(60, 1'b0, 1'b0); send(7, 2); check_counters("post_reset_good");

    // Back-to-back minimum frames with a single idle cycle.
    build(60, 1'b0, 1'b1); send(7, 1);
    build(60, 1'b0, 1'b0); send(7, 2); check_counters("b2b");

    // Length boundaries and short discards.
    build(59, 1'b0, 1'b0);   send(1, 1);
    build(1514, 1'b0, 1'b0); send(3, 1);
    build(1515, 1'b0, 1'b0); send(12, 2); check_counters("len_bounds");
    build(1, 1'b0, 1'b0);    send(7, 2); check_counters("one_byte");
    for (int s = 0; s <= 4; s++) begin
      post_q.delete();
      for (int k = 0; k < s; k++) post_q.push_back(8'($urandom));
      send(7, 1);
    end
    check_counters("short");

    // Randomized mix.
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        send_nosfd($urandom_range(1, 9), $urandom_range(0, 12));
      end else if (kind == 1) begin
        post_q.delete();
        repeat ($urandom_range(0, 4)) post_q.push_back(8'($urandom));
        send($urandom_range(1, 9), $urandom_range(1, 3));
      end else begin
        build($urandom_range(30, 120), ($urandom_range(0, 3) == 0), 1'b0);
        send($urandom_range(1, 9), $urandom_range(1, 3));
      end
      if (it % 8 == 7) check_counters("random");
    end

    repeat (12) put(1'b0, 8'h00);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    check_counters("final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
